// File: rtl/clock_divider.sv
// -----------------------------------------------------------------------------
// clock_divider
//
// Integer clock divider. A phase counter runs 0..N-1. clk_out is a flop that
// is low for L = N - N/2 phases and high for H = N/2 phases. Even N gives a
// 50% duty cycle. Odd N gives one extra low cycle. clk_out is a data-path
// signal in the clk domain, so it changes only on rising edges of clk and
// cannot glitch.
//
// Parameters
//   N        divide ratio, N >= 2; clk_out period is N clk cycles
//
// Ports
//   clk      system clock; all state updates on its rising edge
//   reset    synchronous, active-high; clears the phase and forces clk_out low
//   clk_out  divided clock, driven directly from a flop
// -----------------------------------------------------------------------------
module clock_divider #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  output logic clk_out
);

  // Phase counter width. It must be at least one bit wide.
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  // Number of high cycles per period.
  localparam int H  = N / 2;
  // Number of low cycles per period. The high phase starts at this count.
  localparam int L  = N - H;

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_HIGH = CW'(L);

  generate
    if (N < 2) begin : g_bad_ratio
      $error("clock_divider: N must be >= 2");
    end
  endgenerate

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // The output is decoded from the next phase, not the current one. This lets
  // the registered clk_out line up with cnt on the same edge. With no extra
  // lag, the first rise lands on the L-th edge after reset is released.
  always_comb begin
    // NOTE: give every always_comb target a value on every path (here a
    // default first); a path that leaves it unassigned infers a latch.
    cnt_nxt = cnt + CW'(1);
    if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (reset) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      clk_out <= (cnt_nxt >= CNT_HIGH);
    end
  end

endmodule

// File: tb/tb_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_clock_divider
//
// Directed bench for clock_divider. It uses three instances (N = 4, 5, 2) on
// a shared 10 ns clock. Each instance has its own reset, so one divider can
// be reset mid-stream while the others keep running. Outputs are sampled on
// the falling edge of clk, halfway between active edges.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_clock_divider;

  logic clk;
  logic rst4, rst5, rst2;
  logic out4, out5, out2;

  int checks = 0;
  int errors = 0;

  clock_divider #(.N(4)) dut4 (.clk(clk), .reset(rst4), .clk_out(out4));
  clock_divider #(.N(5)) dut5 (.clk(clk), .reset(rst5), .clk_out(out5));
  clock_divider #(.N(2)) dut2 (.clk(clk), .reset(rst2), .clk_out(out2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time,
             observed, expected);
    end
  endtask

  // Watchdog: the directed sequence finishes within about 1 us.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (CHECKS %0d)", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Expected clk_out after post-reset edges 25, 35, ... 115 ns.
    // Index k is the sample taken at 30 + 10k ns.
    logic [0:9] exp4;
    logic [0:9] exp5;
    logic [0:9] exp2;
    logic [0:7] exp4_restart;
    logic [0:2] exp5_restart;
    logic       prev;
    int         guard;
    int         hi;
    int         lo;
    time        t0;

    exp4         = 10'b0110011001;
    exp5         = 10'b0011000110;
    exp2         = 10'b1010101010;
    exp4_restart = 8'b01100110;
    exp5_restart = 3'b001;

    // ---- Reset phase: rising edges at 5 and 15 ns see reset = 1 ----
    rst4 = 1'b1; rst5 = 1'b1; rst2 = 1'b1;
    @(negedge clk);                              // 10 ns
    check("reset_out4_10ns", out4, 0);
    check("reset_out5_10ns", out5, 0);
    check("reset_out2_10ns", out2, 0);
    check("reset_cnt4_10ns", dut4.cnt, 0);
    @(negedge clk);                              // 20 ns
    check("reset_out4_20ns", out4, 0);
    rst4 = 1'b0; rst5 = 1'b0; rst2 = 1'b0;

    // ---- Tests 1, 3, 4: waveforms after release (edges 25..115 ns) ----
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("n4_wave_k%0d", k), out4, exp4[k]);
      check($sformatf("n5_wave_k%0d", k), out5, exp5[k]);
      check($sformatf("n2_wave_k%0d", k), out2, exp2[k]);
    end

    // ---- Test 2: N=4 steady state over 10 periods ----
    // First align to a sample where out4 has just risen.
    guard = 0;
    prev  = out4;
    @(negedge clk);
    while (!(prev == 1'b0 && out4 == 1'b1) && guard < 8) begin
      prev = out4;
      @(negedge clk);
      guard++;
    end
    check("n4_align_rise_found", (guard < 8), 1);
    for (int p = 0; p < 10; p++) begin
      t0 = $time;
      hi = 0;
      lo = 0;
      while (out4 == 1'b1 && hi < 8) begin hi++; @(negedge clk); end
      while (out4 == 1'b0 && lo < 8) begin lo++; @(negedge clk); end
      check($sformatf("n4_high_cycles_p%0d", p), hi, 2);
      check($sformatf("n4_low_cycles_p%0d", p), lo, 2);
      check($sformatf("n4_period_ns_p%0d", p), 32'($time - t0), 40);
    end

    // ---- Test 5: one-edge reset while out4 is high ----
    check("n4_high_before_reset", out4, 1);
    rst4 = 1'b1;
    @(negedge clk);
    check("n4_out_after_reset", out4, 0);
    check("n4_cnt_after_reset", dut4.cnt, 0);
    rst4 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("n4_restart_k%0d", k), out4, exp4_restart[k]);
    end

    // ---- Test 6: hold reset for 10 edges on the N=5 instance ----
    rst5 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("n5_hold_out_k%0d", k), out5, 0);
      check($sformatf("n5_hold_cnt_k%0d", k), dut5.cnt, 0);
    end
    rst5 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("n5_restart_k%0d", k), out5, exp5_restart[k]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
